vga_fb_reader: RTL
==================

VGA_FB_READER -- requirements
Module: vga_fb_reader

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- FB_W, 400: framebuffer width in pixels.
- FB_H, 300: framebuffer height in lines.
- ADDR_W, 17: framebuffer address width.
- MEM_LAT, 2: fixed framebuffer read latency in cycles, legal range 1..4.
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- VGA_CLK, in, 1: pixel clock. The block has one clock.
- RST, in, 1: reset, asynchronous, active-high.
- VGA_HS_IN, in, 1: upstream horizontal sync, active-low.
- VGA_VS_IN, in, 1: upstream vertical sync, active-low.
- VGA_BLANK_N_IN, in, 1: upstream display-enable, high in the visible area.
- FB_ADDR, out, ADDR_W: framebuffer read address.
- FB_RD, out, 1: framebuffer read strobe.
- FB_DATA, in, 8: RGB332 pixel, valid exactly MEM_LAT cycles after FB_RD.
- VGA_R, VGA_G, VGA_B, out, 8 each: pixel colour.
- VGA_HS, VGA_VS, VGA_BLANK_N, out, 1 each: syncs and blank, delayed to align with colour.
- FRAME_START, out, 1: one-cycle pulse at the start of each frame.

Function
REQ-003 All logic SHALL be clocked on the falling edge of VGA_CLK.
REQ-004 Pixel counter px:
- increments each cycle while VGA_BLANK_N_IN=1;
- clears to 0 on the cycle after a 1->0 transition of VGA_BLANK_N_IN.
REQ-005 Line counter ln:
- increments by 1 on each 1->0 transition of VGA_BLANK_N_IN;
- clears to 0 while VGA_VS_IN=0 (clear has priority over increment).
REQ-006 Scaling and addressing:
- fb_x = px>>1, fb_y = ln>>1 (2x scaling);
- FB_ADDR = fb_y*FB_W + fb_x, generated incrementally from a line-base register that adds FB_W every second line, with no multiplier;
- FB_ADDR is registered one cycle after the input.
REQ-007 FB_RD SHALL be 1 only when all of the following hold; otherwise FB_RD=0 and FB_ADDR holds its last value:
- VGA_BLANK_N_IN=1;
- fb_x < FB_W;
- fb_y < FB_H;
- the synced flag is set.
REQ-008 Colour path latency SHALL be exactly MEM_LAT+2 cycles from input to output:
- one cycle for the address stage;
- MEM_LAT cycles for the memory;
- one output register.
REQ-009 VGA_HS, VGA_VS and VGA_BLANK_N SHALL be VGA_HS_IN, VGA_VS_IN and VGA_BLANK_N_IN delayed by MEM_LAT+2 cycles through a shift register.
REQ-010 RGB332 expansion for a pixel d, when its read was issued:
- VGA_R = {d[7:5], d[7:5], d[7:6]};
- VGA_G = {d[4:2], d[4:2], d[4:3]};
- VGA_B = {d[1:0], d[1:0], d[1:0], d[1:0]}.
REQ-011 The RGB outputs SHALL be 0 for any output cycle whose read was not issued: blanking, out-of-range pixels, and not-synced periods.
REQ-012 FRAME_START SHALL pulse for exactly one cycle on the cycle where the delayed VGA_VS output goes 0->1.
REQ-013 Wrap-around: px and ln SHALL saturate at their all-ones value (11-bit and 10-bit respectively) and never wrap.
REQ-014 Simultaneous events: when a BLANK_N_IN falling edge coincides with VS_IN=0, ln SHALL be 0 on the next cycle.

Reset
REQ-015 While RST=1, the following SHALL be 0:
- px, ln, the line base, the synced flag and all delay stages;
- FB_ADDR, FB_RD, VGA_R, VGA_G, VGA_B and FRAME_START.
REQ-016 While RST=1, VGA_HS, VGA_VS and VGA_BLANK_N SHALL be 0.
REQ-017 After RST deasserts, the synced flag SHALL set on the first cycle with VGA_VS_IN=0.
REQ-018 Until the synced flag is set, FB_RD and RGB SHALL stay 0; a reset mid-frame therefore blanks the picture until the next vertical sync.

Configuration
REQ-019 The macro FB_BORDER_EN SHALL control the border overlay:
- when defined, pixels with fb_x==0, fb_x==FB_W-1, fb_y==0 or fb_y==FB_H-1 output R=G=B=8'hFF, replacing FB_DATA; FB_RD timing is unchanged and the latency stays MEM_LAT+2;
- when undefined, no border logic is present and all pixels come from FB_DATA.

Verification
REQ-020 Latency: MEM_LAT=2, FB_DATA=8'hE0 returned for the first active pixel -> VGA_R=8'hFF, VGA_G=0, VGA_B=0 exactly 4 cycles after the first VGA_BLANK_N_IN=1, aligned with VGA_BLANK_N=1.
REQ-021 Addressing: active line 5, px=7 -> FB_ADDR=2*400+3=803 with FB_RD=1; px=800 on any line -> FB_RD=0 and RGB output 0.
REQ-022 Line/frame: 600 active lines followed by VS_IN low -> ln returns to 0, the next frame's first FB_ADDR=0, and FRAME_START pulses once, 4 cycles after VS_IN rises.
REQ-023 Reset mid-frame: assert RST at line 100, release it at line 102 -> FB_RD=0 and RGB=0 until VS_IN=0, then normal addressing restarts from 0.
REQ-024 Border: with FB_BORDER_EN defined, FB_DATA=8'h00 -> pixel (0,0) and pixel (399,150) output 8'hFF on all channels, while pixel (10,10) outputs 0.

Source files
------------

// File: rtl/vga_fb_reader.sv
// VGA framebuffer reader: 2x-scaled RGB332 fetch from a fixed-latency memory, with sync/blank
// delayed to line up with colour. Defining FB_BORDER_EN paints the framebuffer edge white.
module vga_fb_reader #(
  parameter int FB_W    = 400,
  parameter int FB_H    = 300,
  parameter int ADDR_W  = 17,
  parameter int MEM_LAT = 2
) (
  input  logic              VGA_CLK,
  input  logic              RST,
  input  logic              VGA_HS_IN,
  input  logic              VGA_VS_IN,
  input  logic              VGA_BLANK_N_IN,
  output logic [ADDR_W-1:0] FB_ADDR,
  output logic              FB_RD,
  input  logic [7:0]        FB_DATA,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic              FRAME_START
);
  localparam int                DLY    = MEM_LAT + 2;
  localparam logic [10:0]       FB_W_X = 11'(FB_W);
  localparam logic [9:0]        FB_H_Y = 10'(FB_H);
  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

  logic [10:0]        px_q, px_d;
  logic [9:0]         ln_q, ln_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic               blank_q;
  logic               synced_q;
  logic [ADDR_W-1:0]  fb_addr_q;
  logic               fb_rd_q;
  logic [MEM_LAT-1:0] rd_pipe_q;
  logic [2:0]         sync_q [DLY];
  logic [7:0]         r_q, g_q, b_q;
  logic [7:0]         r_d, g_d, b_d;
  logic               frame_start_q;

  logic               fall_w;
  logic               rd_w;
  logic [10:0]        fb_x_w;
  logic [9:0]         fb_y_w;
  logic [ADDR_W-1:0]  addr_w;

`ifdef FB_BORDER_EN
  logic               bd_w;
  logic [MEM_LAT:0]   bd_pipe_q;

  assign bd_w = (fb_x_w == 11'd0) || (fb_x_w == FB_W_X - 11'd1) ||
                (fb_y_w == 10'd0) || (fb_y_w == FB_H_Y - 10'd1);
`endif

  // Counters, scaling and the multiplier-free address: base_q tracks fb_y*FB_W.
  always_comb begin
    fb_x_w = {1'b0, px_q[10:1]};
    fb_y_w = {1'b0, ln_q[9:1]};
    fall_w = blank_q & ~VGA_BLANK_N_IN;
    rd_w   = VGA_BLANK_N_IN & synced_q & (fb_x_w < FB_W_X) & (fb_y_w < FB_H_Y);
    addr_w = base_q + ADDR_W'(px_q[10:1]);

    px_d = px_q;
    if (VGA_BLANK_N_IN) begin
      if (px_q != '1) px_d = px_q + 11'd1;
    end else if (fall_w) begin
      px_d = '0;
    end

    ln_d   = ln_q;
    base_d = base_q;
    if (!VGA_VS_IN) begin
      ln_d   = '0;
      base_d = '0;
    end else if (fall_w && (ln_q != '1)) begin
      ln_d = ln_q + 10'd1;
      // leaving an odd line means fb_y steps up by one
      if (ln_q[0]) base_d = base_q + FB_W_A;
    end
  end

  // FB_RD/FB_DATA has no ready: FB_DATA is taken exactly MEM_LAT cycles after each FB_RD
  // cycle and ignored on every other cycle.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (rd_pipe_q[MEM_LAT-1]) begin
      r_d = {FB_DATA[7:5], FB_DATA[7:5], FB_DATA[7:6]};
      g_d = {FB_DATA[4:2], FB_DATA[4:2], FB_DATA[4:3]};
      b_d = {4{FB_DATA[1:0]}};
`ifdef FB_BORDER_EN
      if (bd_pipe_q[MEM_LAT]) begin
        r_d = '1;
        g_d = '1;
        b_d = '1;
      end
`endif
    end
  end

  always_ff @(negedge VGA_CLK or posedge RST) begin
    if (RST) begin
      px_q          <= '0;
      ln_q          <= '0;
      base_q        <= '0;
      blank_q       <= 1'b0;
      synced_q      <= 1'b0;
      fb_addr_q     <= '0;
      fb_rd_q       <= 1'b0;
      rd_pipe_q     <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      frame_start_q <= 1'b0;
      for (int i = 0; i < DLY; i++) sync_q[i] <= '0;
`ifdef FB_BORDER_EN
      bd_pipe_q     <= '0;
`endif
    end else begin
      px_q     <= px_d;
      ln_q     <= ln_d;
      base_q   <= base_d;
      blank_q  <= VGA_BLANK_N_IN;
      synced_q <= synced_q | ~VGA_VS_IN;
      fb_rd_q  <= rd_w;
      if (rd_w) fb_addr_q <= addr_w;
      rd_pipe_q[0] <= fb_rd_q;
      for (int i = 1; i < MEM_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
      sync_q[0] <= {VGA_HS_IN, VGA_VS_IN, VGA_BLANK_N_IN};
      for (int i = 1; i < DLY; i++) sync_q[i] <= sync_q[i-1];
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
      // next-cycle VGA_VS is high while the current one is low
      frame_start_q <= sync_q[DLY-2][1] & ~sync_q[DLY-1][1];
`ifdef FB_BORDER_EN
      bd_pipe_q[0] <= bd_w;
      for (int i = 1; i <= MEM_LAT; i++) bd_pipe_q[i] <= bd_pipe_q[i-1];
`endif
    end
  end

  assign FB_ADDR     = fb_addr_q;
  assign FB_RD       = fb_rd_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = sync_q[DLY-1][2];
  assign VGA_VS      = sync_q[DLY-1][1];
  assign VGA_BLANK_N = sync_q[DLY-1][0];
  assign FRAME_START = frame_start_q;

endmodule
